// File: rtl/led_tube_pkg.sv
// led_tube_pkg: register map defaults, CTRL bit layout and active-low hex glyphs for led_tube.
package led_tube_pkg;
  localparam logic [31:0] DEF_LED_ADDR  = 32'h0000_7f34;
  localparam logic [31:0] DEF_TUBE_ADDR = 32'h0000_7f38;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'h0000_7f3c;
  localparam int CTRL_BLANK_LSB = 0;
  localparam int CTRL_EN = 8;
  localparam int CTRL_LZB = 9;
  localparam int CTRL_DP_LSB = 16;
  localparam logic [31:0] CTRL_RST = 32'h0000_0100;
  localparam logic [31:0] CTRL_WMASK = 32'h00FF_03FF;
  // {g,f,e,d,c,b,a}, index 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/led_tube_seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low 7-segment glyph.
module seg7_decode
  import led_tube_pkg::*;
(
  input  logic [3:0] d,
  output logic [6:0] g
);
  assign g = GLYPH[d];
endmodule

// File: rtl/led_tube.sv
// led_tube: bus-mapped LED register plus 8-digit multiplexed 7-segment scanner.
// Define LED_TUBE_LZB_EN to add leading-zero blanking controlled by CTRL bit 9.
module led_tube
  import led_tube_pkg::*;
#(
  parameter int          SCAN_DIV  = 50000,
  parameter logic [31:0] LED_ADDR  = DEF_LED_ADDR,
  parameter logic [31:0] TUBE_ADDR = DEF_TUBE_ADDR,
  parameter logic [31:0] CTRL_ADDR = DEF_CTRL_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ADD_I,
  input  logic [31:0] DAT_I,
  input  logic        WE_I,
  output logic [31:0] DAT_O,
  output logic [31:0] led,
  output logic [7:0]  an,
  output logic [7:0]  seg
);
  localparam logic [20:0] CNT_MAX = 21'(SCAN_DIV - 1);
`ifdef LED_TUBE_LZB_EN
  localparam logic [31:0] WMASK = CTRL_WMASK;
`else
  localparam logic [31:0] WMASK = CTRL_WMASK & ~(32'd1 << CTRL_LZB);
`endif
  logic [31:0] led_r, tube_r, ctrl_r;
  logic [20:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  blank, dp;
  logic [6:0]  glyph;
  logic        lzb_dark, dark;
  seg7_decode u_dec (.d(tube_r[{idx, 2'b00} +: 4]), .g(glyph));
  assign blank = ctrl_r[CTRL_BLANK_LSB +: 8];
  assign dp    = ctrl_r[CTRL_DP_LSB +: 8];
`ifdef LED_TUBE_LZB_EN
  // dark when this digit and every digit above it are zero; digit 0 never blanked
  assign lzb_dark = ctrl_r[CTRL_LZB] && idx != 3'd0 && (tube_r >> {idx, 2'b00}) == 32'd0;
`else
  assign lzb_dark = 1'b0;
`endif
  assign dark  = !ctrl_r[CTRL_EN] || blank[idx] || lzb_dark;
  assign led   = ~led_r;
  assign DAT_O = ADD_I == LED_ADDR  ? led_r  :
                 ADD_I == TUBE_ADDR ? tube_r :
                 ADD_I == CTRL_ADDR ? ctrl_r : 32'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_r  <= '0;
      tube_r <= '0;
      ctrl_r <= CTRL_RST;
      cnt    <= '0;
      idx    <= '0;
      an     <= '1;
      seg    <= '1;
    end else begin
      if (WE_I && ADD_I == LED_ADDR) led_r <= DAT_I;
      if (WE_I && ADD_I == TUBE_ADDR) tube_r <= DAT_I;
      if (WE_I && ADD_I == CTRL_ADDR) ctrl_r <= DAT_I & WMASK;
      cnt <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
      if (cnt == CNT_MAX) idx <= idx + 1'b1;
      an  <= dark ? 8'hFF : ~(8'h01 << idx);
      seg <= dark ? 8'hFF : {~dp[idx], glyph};
    end
  end
endmodule

// File: doc/led_tube.md
LED_TUBE -- requirements
Module: led_tube

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each digit is driven (legal 2..2^20).
REQ-002 SHALL have parameter LED_ADDR, default 32'h0000_7f34, LED register word address.
REQ-003 SHALL have parameter TUBE_ADDR, default 32'h0000_7f38, tube data register address.
REQ-004 SHALL have parameter CTRL_ADDR, default 32'h0000_7f3c, control register address.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ADD_I  input  32  bus word address.
REQ-008 DAT_I  input  32  bus write data.
REQ-009 WE_I  input  1  bus write strobe, one cycle per write.
REQ-010 DAT_O  output  32  combinational read data.
REQ-011 led  output  32  board LEDs, active-low.
REQ-012 an  output  8  digit enables, active-low, bit i = digit i.
REQ-013 seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-014 Registers: LED_R[31:0], TUBE_R[31:0] (digit i = TUBE_R[4i+3:4i]), CTRL_R: [7:0] blank mask, [8] display enable, [9] leading-zero blank (macro only), [23:16] dp mask; other bits read 0.
REQ-015 WE_I with ADD_I equal to a register address SHALL write the full word at that clk edge; other addresses SHALL be ignored.
REQ-016 DAT_O SHALL return the addressed register's current value, 0 for any other address; same-cycle write is not bypassed.
REQ-017 led SHALL equal ~LED_R, registered, updating the cycle after the write.
REQ-018 Scan counter cnt SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index idx SHALL advance 0..7, 7 wrapping to 0.
REQ-019 an and seg SHALL be registered from idx, TUBE_R, CTRL_R with one-cycle latency; register writes SHALL be visible on the current digit without waiting for the scan.
REQ-020 Digit idx SHALL be dark (an=8'hFF, seg=8'hFF) when CTRL_R[8]=0 or CTRL_R[idx]=1; otherwise an=~(8'b1<<idx).
REQ-021 seg[6:0] SHALL be the active-low hex glyph of digit idx (0-9, A-F, lowercase b,d); seg[7]=~CTRL_R[16+idx].
REQ-022 A write during an active scan SHALL NOT restart cnt or idx.

Reset
REQ-023 While reset low: LED_R=0, TUBE_R=0, CTRL_R=32'h0000_0100, cnt=0, idx=0, led=32'hFFFF_FFFF, an=8'hFF, seg=8'hFF.
REQ-024 Reset assertion mid-scan SHALL force REQ-023 values immediately; the first digit driven after release SHALL be digit 0, from the cycle after the first clk edge.

Configuration
REQ-025 Macro LED_TUBE_LZB_EN defined: CTRL_R[9] writable; when 1, digits above the highest nonzero digit SHALL be dark, digit 0 always lit unless masked.
REQ-026 Macro undefined: CTRL_R[9] SHALL read 0, writes ignored, no blanking logic synthesized.

Structure
REQ-027 Shared package led_tube_pkg SHALL hold the default register addresses, CTRL bit positions and the 16-entry active-low glyph constants.
REQ-028 Sub-module seg7_decode SHALL be the combinational 4-bit to 7-segment glyph decoder; all state stays in led_tube.

Verification (SCAN_DIV=4)
REQ-029 Reset release, no writes -> an cycles FE,FD,...,7F every 4 clk; seg=8'hC0 ('0', dp off) each digit.
REQ-030 Write TUBE_ADDR 32'h89AB_CDEF -> digit0 seg=8'h8E ('F'), digit7 seg=8'h80 ('8'); DAT_O at TUBE_ADDR=32'h89AB_CDEF.
REQ-031 Write LED_ADDR 32'h0000_00F0 -> next cycle led=32'hFFFF_FF0F; read of 32'h0000_7f40 -> DAT_O=0.
REQ-032 Write CTRL_ADDR 32'h0001_0102 -> digit1 an=8'hFF/seg=8'hFF; digit0 seg[7]=0; then CTRL=0 -> an=8'hFF for all idx.
REQ-033 LZB_EN, TUBE=32'h0000_0012, CTRL=32'h0000_0300 -> digits 0,1 lit, digits 2-7 an=8'hFF; without macro CTRL reads 32'h0000_0100.
REQ-034 reset pulsed low at idx=5, mid-count -> outputs at REQ-023 values asynchronously; scan resumes at digit 0.
